// File: rtl/dec2to4_al_reg_pkg.sv
// Shared constants and the active-low 2-to-4 decode function for dec2to4_al_reg.
package dec2to4_al_reg_pkg;

  localparam int SEL_W = 2;
  localparam logic [3:0] Y_DESEL = 4'b1111;
  // Idle input sample {G_L, B, A}: disabled, select 00.
  localparam logic [SEL_W:0] IN_IDLE = 3'b100;

  function automatic logic [3:0] dec2to4_al(input logic g_l, input logic [SEL_W-1:0] sel);
    logic [3:0] y;
    y = Y_DESEL;
    if (g_l == 1'b0) begin
      case (sel)
        2'b00:   y = 4'b1110;
        2'b01:   y = 4'b1101;
        2'b10:   y = 4'b1011;
        2'b11:   y = 4'b0111;
        default: y = Y_DESEL;
      endcase
    end else begin
      y = Y_DESEL;
    end
    return y;
  endfunction

endpackage

// File: rtl/dec2to4_al_reg_chk.sv
// Simulation checker: the decoded output vector is all-high or has exactly one low bit.
module dec2to4_al_reg_chk (
  input logic       clk,
  input logic       rst,
  input logic [3:0] y
);

  // At most one active-low output may be asserted at any edge.
  a_one_low_max: assert property (@(posedge clk) disable iff (rst) ($countones(~y) <= 1))
    else $error("dec2to4_al_reg: more than one output low, y=%b", y);

endmodule

// File: rtl/dec2to4_al_reg_pipe_reg.sv
// Fixed-depth register pipeline with synchronous reset of every stage to RST_VAL.
module dec2to4_al_reg_pipe_reg #(
  parameter int W = 1,
  parameter int DEPTH = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_r [DEPTH];

  // Shift the sample one stage per clock; reset clears the whole chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= RST_VAL;
      end
    end else begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/dec2to4_al_reg.sv
// Registered half of a 74x139: optional input pipeline, then decode into an output register.
module dec2to4_al_reg
  import dec2to4_al_reg_pkg::*;
#(
  parameter int IN_STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic G_L,
  input  logic A,
  input  logic B,
  output logic Y0_L,
  output logic Y1_L,
  output logic Y2_L,
  output logic Y3_L
);

  logic [SEL_W:0] in_s;
  logic [SEL_W:0] dly_s;
  logic [3:0]     y_r;

  assign in_s = {G_L, B, A};

  generate
    if (IN_STAGES > 0) begin : g_pipe
      dec2to4_al_reg_pipe_reg #(
        .W       (SEL_W + 1),
        .DEPTH   (IN_STAGES),
        .RST_VAL (IN_IDLE)
      ) u_in_pipe (
        .clk (clk),
        .rst (rst),
        .d   (in_s),
        .q   (dly_s)
      );
    end else begin : g_nopipe
      assign dly_s = in_s;
    end
  endgenerate

  // Decode the delayed sample; the register keeps select changes glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r <= Y_DESEL;
    end else begin
      y_r <= dec2to4_al(dly_s[SEL_W], dly_s[SEL_W-1:0]);
    end
  end

  assign Y0_L = y_r[0];
  assign Y1_L = y_r[1];
  assign Y2_L = y_r[2];
  assign Y3_L = y_r[3];

  dec2to4_al_reg_chk u_chk (
    .clk (clk),
    .rst (rst),
    .y   (y_r)
  );

endmodule

// File: tb/tb_dec2to4_al_reg.sv
// Directed + random bench for dec2to4_al_reg with IN_STAGES = 0 and 2 driven in parallel.
module tb_dec2to4_al_reg;

  logic clk = 1'b0;
  logic rst;
  logic G_L;
  logic A;
  logic B;
  logic [3:0] y0;
  logic [3:0] y2;
  logic [2:0] hist [3];
  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  dec2to4_al_reg #(.IN_STAGES(0)) dut0 (
    .clk (clk), .rst (rst), .G_L (G_L), .A (A), .B (B),
    .Y0_L (y0[0]), .Y1_L (y0[1]), .Y2_L (y0[2]), .Y3_L (y0[3])
  );

  dec2to4_al_reg #(.IN_STAGES(2)) dut2 (
    .clk (clk), .rst (rst), .G_L (G_L), .A (A), .B (B),
    .Y0_L (y2[0]), .Y1_L (y2[1]), .Y2_L (y2[2]), .Y3_L (y2[3])
  );

  // Golden decode of a {G_L, B, A} sample, written as a shifted one-hot.
  function automatic logic [3:0] golden(input logic [2:0] s);
    logic [3:0] m;
    m = 4'b0001 << s[1:0];
    if (s[2]) return 4'b1111;
    return ~m;
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, clock them in, update the sample history, check both DUTs.
  task automatic cyc(input logic r, input logic g, input logic b, input logic a,
                     input logic [3:0] exp0, input string tag);
    logic [3:0] e2;
    rst = r; G_L = g; B = b; A = a;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 3; i++) hist[i] = 3'b100;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = {g, b, a};
    end
    e2 = golden(hist[2]);
    check({tag, "_s0"}, y0, exp0);
    check({tag, "_s2"}, y2, e2);
    n_cmp++;
    assert ($countones(~y2) <= 1) else begin
      n_mis++;
      $error("FAIL %s_onehot observed=%b expected=at most one low", tag, y2);
    end
  endtask

  initial begin
    logic rr, rg, rb, ra;
    for (int i = 0; i < 3; i++) hist[i] = 3'b100;

    // Reset held two cycles with inputs that would otherwise select Y3.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, "rst_a");
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'b1111, "rst_b");

    // Enabled sweep of all select codes.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, "sw00");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, "sw01");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b1011, "sw10");
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 4'b0111, "sw11");

    // Disabled sweep: everything deselected.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, "dis00");
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 4'b1111, "dis01");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, "dis10");
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, "dis11");

    // Enable toggle on select 10.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b1011, "tg0");
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'b1111, "tg1");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'b1011, "tg2");

    // Single-cycle reset in the middle of steady select 01.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, "mr0");
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'b1111, "mr1");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, "mr2");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, "mr3");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, "mr4");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'b1101, "mr5");

    // Random traffic with occasional resets against the delayed golden model.
    for (int i = 0; i < 1000; i++) begin
      rr = ($urandom_range(0, 49) == 0);
      rg = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      ra = 1'($urandom_range(0, 1));
      cyc(rr, rg, rb, ra, rr ? 4'b1111 : golden({rg, rb, ra}), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
